// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
// Write bus from the instruction loader into instruction memory.
//
// Signals:
//   imem_wr_en    one-cycle write strobe
//   imem_wr_addr  write address (ADDR_WIDTH bits)
//   imem_wr_data  16-bit instruction word {high_byte, low_byte}
//
// Modports:
//   master  the loader, drives the bus
//   slave   the instruction memory, receives the bus
// -----------------------------------------------------------------------------
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  imem_wr_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [15:0]           imem_wr_data;

    modport master (
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );

    modport slave (
        input imem_wr_en,
        input imem_wr_addr,
        input imem_wr_data
    );
endinterface

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Upstream feeder for the processor's instruction memory. The push-button is
// synchronized and debounced; each clean press captures the 8-bit switch bank,
// low byte first, then high byte. A completed 16-bit word is written into
// instruction memory at an auto-incrementing address, and the word under
// assembly is mirrored on the LEDs.
//
// Parameters:
//   DEBOUNCE_CYCLES  enabled cycles a synchronized level must hold to be accepted
//   ADDR_WIDTH       instruction memory address width
//   DEPTH            number of loadable words (must not exceed 2**ADDR_WIDTH)
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous, active-low reset
//   clk_enable         in   advances debounce, FSM and pointer only when 1
//   input_instruction  in   [7:0] switch byte being entered
//   button             in   raw, asynchronous, bouncy load button
//   load_mode          in   1 = loading permitted, 0 = presses ignored / partial word dropped
//   imem               master modport of instr_loader_if (write strobe, address, data)
//   led_ins            out  [15:0] word under assembly
//   load_count         out  [ADDR_WIDTH:0] words written so far
//   byte_phase         out  0 = expecting low byte, 1 = expecting high byte
//   full               out  DEPTH words written
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDR_WIDTH      = 6,
    parameter int DEPTH           = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    input  logic [7:0]          input_instruction,
    input  logic                button,
    input  logic                load_mode,
    instr_loader_if.master      imem,
    output logic [15:0]         led_ins,
    output logic [ADDR_WIDTH:0] load_count,
    output logic                byte_phase,
    output logic                full
);

    localparam int                  CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0]    DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LO,
        S_HI,
        S_WR,
        S_FULL
    } state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer: free-running, independent of clk_enable.
    // -------------------------------------------------------------------------
    logic sync1_q, sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: count consecutive enabled cycles where the synchronized button
    // disagrees with the accepted level; any agreement restarts the count.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             db_prev_q;
    logic             press_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (clk_enable) begin
            if (sync2_q == db_level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            // Press pulse is held across frozen cycles so the FSM sees it on
            // the next enabled cycle; it lasts exactly one enabled cycle.
            if (clk_enable) begin
                db_prev_q <= db_level_q;
                press_q   <= db_level_q & ~db_prev_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load FSM with registered outputs.
    // -------------------------------------------------------------------------
    state_e                state_q;
    logic [15:0]           led_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  phase_q;
    logic                  full_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LO;
            led_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            phase_q <= 1'b0;
            full_q  <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                S_LO: begin
                    // led_q keeps showing the last written word until here.
                    if (press_q && load_mode) begin
                        led_q   <= {8'h00, input_instruction};
                        phase_q <= 1'b1;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (!load_mode) begin
                        // Abandon the partial word; the pointer is untouched.
                        led_q   <= '0;
                        phase_q <= 1'b0;
                        state_q <= S_LO;
                    end else if (press_q) begin
                        led_q[15:8] <= input_instruction;
                        state_q     <= S_WR;
                    end
                end
                S_WR: begin
                    // load_mode is deliberately ignored: a committed write completes.
                    count_q <= count_q + 1'b1;
                    phase_q <= 1'b0;
                    if (count_q == COUNT_LAST) begin
                        // Last slot written: the pointer stays on DEPTH-1
                        // rather than stepping past the end of memory.
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= S_LO;
                    end
                end
                S_FULL: begin
                    // Terminal until reset; presses are dropped.
                end
                default: state_q <= S_LO;
            endcase
        end
    end

    // The strobe is qualified by clk_enable so a frozen WR never writes twice.
    assign imem.imem_wr_en   = (state_q == S_WR) & clk_enable;
    assign imem.imem_wr_addr = ptr_q;
    assign imem.imem_wr_data = led_q;

    assign led_ins    = led_q;
    assign load_count = count_q;
    assign byte_phase = phase_q;
    assign full       = full_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Self-checking bench for instr_loader. Stimulus tasks update a word-level
// reference model (bytes, phase, count) and push every expected memory write
// into a scoreboard queue; a monitor pops and compares on each write strobe.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int DB    = 4;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int HOLD  = DB + 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          en_manual;
    logic          en_rand;
    logic [7:0]    sw;
    logic          button;
    logic          load_mode;
    logic [15:0]   led_ins;
    logic [AW:0]   load_count;
    logic          byte_phase;
    logic          full;

    instr_loader_if #(.ADDR_WIDTH(AW)) imem ();

    instr_loader #(
        .DEBOUNCE_CYCLES(DB),
        .ADDR_WIDTH     (AW),
        .DEPTH          (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_enable       (clk_enable),
        .input_instruction(sw),
        .button           (button),
        .load_mode        (load_mode),
        .imem             (imem),
        .led_ins          (led_ins),
        .load_count       (load_count),
        .byte_phase       (byte_phase),
        .full             (full)
    );

    always #5 clk = ~clk;

    assign clk_enable = en_manual & en_rand;

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    bit  rand_en  = 1'b0;

    // Reference model, word level.
    int          m_count;
    bit          m_phase;
    logic [15:0] m_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem.imem_wr_en === 1'b1) begin
            n_writes++;
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem.imem_wr_addr), 32'(e.addr));
                check("wr_data", 32'(imem.imem_wr_data), 32'(e.data));
            end
        end
    end

    // Random clock-enable gaps, active only in the randomized phase.
    always @(negedge clk) begin
        en_rand = rand_en ? ($urandom_range(3) != 0) : 1'b1;
    end

    // ---------------------------------------------------------------- model ops
    task automatic model_reset();
        m_count = 0;
        m_phase = 1'b0;
        m_led   = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_abort();
        if (m_count < DEPTH && m_phase) begin
            m_phase = 1'b0;
            m_led   = 16'h0000;
        end
    endtask

    task automatic model_press(input logic [7:0] b);
        if (m_count >= DEPTH) return;
        if (!load_mode) begin
            model_abort();
            return;
        end
        if (!m_phase) begin
            m_led   = {8'h00, b};
            m_phase = 1'b1;
        end else begin
            m_led[15:8] = b;
            exp_q.push_back('{addr: AW'(m_count), data: m_led});
            m_count++;
            m_phase = 1'b0;
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic wait_en(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 40 + 100) begin
            @(posedge clk);
            cyc++;
            if (clk_enable) got++;
        end
        if (got < n) check("wait_en_timeout", 32'(got), 32'(n));
        #1;
    endtask

    task automatic press(input logic [7:0] b, input int bounces);
        model_press(b);
        sw = b;
        for (int i = 0; i < bounces; i++) begin
            button = 1'b1;
            repeat (2) @(posedge clk);
            button = 1'b0;
            repeat (2) @(posedge clk);
        end
        button = 1'b1;
        wait_en(HOLD);
        button = 1'b0;
        wait_en(HOLD);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_phase"}, 32'(byte_phase), 32'(m_phase));
        check({tag, "_led"},   32'(led_ins),    32'(m_led));
        check({tag, "_count"}, 32'(load_count), 32'(m_count));
        check({tag, "_full"},  32'(full),       32'(m_count == DEPTH));
    endtask

    // Asserts reset mid-cycle (no clock edge) and checks outputs immediately.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_wr_en",   32'(imem.imem_wr_en),   32'd0);
        check("rst_wr_addr", 32'(imem.imem_wr_addr), 32'd0);
        check("rst_wr_data", 32'(imem.imem_wr_data), 32'd0);
        check("rst_led",     32'(led_ins),           32'd0);
        check("rst_count",   32'(load_count),        32'd0);
        check("rst_phase",   32'(byte_phase),        32'd0);
        check("rst_full",    32'(full),              32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_en(2);
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        int w0;
        bit found;

        reset     = 1'b0;
        en_manual = 1'b1;
        en_rand   = 1'b1;
        sw        = 8'h00;
        button    = 1'b0;
        load_mode = 1'b1;
        model_reset();

        // 1. Clean load.
        apply_reset();
        w0 = n_writes;
        press(8'h34, 0);
        press(8'h12, 0);
        check("t1_writes", 32'(n_writes - w0), 32'd1);
        check("t1_led", 32'(led_ins), 32'h1234);
        check_state("t1");

        // 2. Bounce rejection: one capture only, no write.
        apply_reset();
        w0 = n_writes;
        press(8'h5A, 2);
        check("t2_writes", 32'(n_writes - w0), 32'd0);
        check_state("t2");

        // 3. Abort then a fresh word.
        apply_reset();
        w0 = n_writes;
        press(8'hAA, 0);
        check("t3_phase_hi", 32'(byte_phase), 32'd1);
        load_mode = 1'b0;
        model_abort();
        wait_en(1);
        load_mode = 1'b1;
        check_state("t3_abort");
        press(8'h55, 0);
        press(8'h66, 0);
        check("t3_writes", 32'(n_writes - w0), 32'd1);
        check_state("t3");

        // 4. Fill to DEPTH, then attempt one more word.
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            press(8'(i), 0);
            press(8'h00, 0);
        end
        check("t4_full", 32'(full), 32'd1);
        w0 = n_writes;
        press(8'h77, 0);
        press(8'h88, 0);
        check("t4_no_fifth", 32'(n_writes - w0), 32'd0);
        check_state("t4");

        // 5. Freeze while the write is pending.
        apply_reset();
        w0 = n_writes;
        press(8'h21, 0);
        model_press(8'h43);
        sw     = 8'h43;
        button = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            #1;
            if (byte_phase && led_ins[15:8] == 8'h43) found = 1'b1;
        end
        en_manual = 1'b0;
        check("t5_reached_wr", 32'(found), 32'd1);
        repeat (8) begin
            @(negedge clk);
            check("t5_frozen_wr_en", 32'(imem.imem_wr_en), 32'd0);
            check("t5_frozen_count", 32'(load_count), 32'd0);
        end
        @(posedge clk);
        #1;
        en_manual = 1'b1;
        check("t5_addr_held", 32'(imem.imem_wr_addr), 32'd0);
        button = 1'b0;
        wait_en(HOLD);
        check("t5_writes", 32'(n_writes - w0), 32'd1);
        check_state("t5");

        // 6. Asynchronous reset while in HI, then a word lands at address 0.
        apply_reset();
        press(8'h99, 0);
        check("t6_phase_hi", 32'(byte_phase), 32'd1);
        apply_reset();
        w0 = n_writes;
        press(8'h11, 0);
        press(8'h22, 0);
        check("t6_writes", 32'(n_writes - w0), 32'd1);
        check_state("t6");

        // 7. Randomized operation with enable gaps, bounces and aborts.
        rand_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            for (int k = 0; k < 14; k++) begin
                int op;
                op = int'($urandom_range(9));
                if (op == 0) begin
                    load_mode = 1'b0;
                    model_abort();
                    wait_en(2);
                    load_mode = 1'b1;
                end else if (op == 1) begin
                    load_mode = 1'b0;
                    press(8'($urandom), 0);
                    load_mode = 1'b1;
                end else begin
                    press(8'($urandom), int'($urandom_range(2)));
                end
                check_state("rnd");
            end
        end
        rand_en = 1'b0;
        wait_en(4);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
